// File: rtl/uart_byte_fifo_pkg.sv
// rtl/uart_byte_fifo_pkg.sv - shared widths, default depth and flow-stop helper for the UART byte FIFO
package uart_byte_fifo_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int FIFO_DEPTH_LOG2_DEF  = 4;

    // Hysteretic flow-stop: set at/above the high mark, clear at/below the low mark, else hold.
    function automatic logic flow_stop_next(input logic cur, input logic at_hi, input logic at_lo);
        logic nxt;
        nxt = cur;
        if (at_hi) begin
            nxt = 1'b1;
        end else if (at_lo) begin
            nxt = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - byte storage array with synchronous write and asynchronous read
module uart_fifo_mem
    import uart_byte_fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_DEPTH_LOG2_DEF,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Contents are don't-care after reset, so the array carries no reset and maps to distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - first-word-fall-through byte FIFO with hysteretic flow stop and sticky overflow
module uart_byte_fifo
    import uart_byte_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF,
    parameter int STOP_HI    = (2**DEPTH_LOG2) - 4,
    parameter int STOP_LO    = (2**DEPTH_LOG2) / 2
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   in_req,
    output logic                   in_ready,
    input  logic [UART_DATA_W-1:0] in_data,
    output logic                   out_req,
    input  logic                   out_ready,
    output logic [UART_DATA_W-1:0] out_data,
    output logic                   flow_stop,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic [DEPTH_LOG2:0]    level
);

    localparam int                  LW      = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0]       DEPTH_L = LW'(2**DEPTH_LOG2);
    localparam logic [LW-1:0]       HI_L    = LW'(STOP_HI);
    localparam logic [LW-1:0]       LO_L    = LW'(STOP_LO);
    localparam logic [LW-1:0]       LVL_ONE = LW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  flow_stop_q, flow_stop_d;
    logic                  overflow_q, overflow_d;
    logic                  push, pop;

    // Handshakes come only from registered level, so in_req never reaches out_req combinationally.
    assign in_ready  = (level_q != DEPTH_L);
    assign out_req   = (level_q != '0);
    assign push      = in_req & in_ready;
    assign pop       = out_req & out_ready;
    assign level     = level_q;
    assign flow_stop = flow_stop_q;
    assign overflow  = overflow_q;

    uart_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (UART_DATA_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (in_data),
        .rd_addr (rd_ptr_q),
        .rd_data (out_data)
    );

    // Next-state for pointers, occupancy, and the flags that track the upcoming occupancy.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // A dropped byte outranks a same-cycle clear so no overflow event is lost.
        if (in_req && !in_ready) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        flow_stop_d = flow_stop_next(flow_stop_q, level_d >= HI_L, level_d <= LO_L);
    end

    // State register; reset discards all stored bytes by zeroing pointers and occupancy.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            flow_stop_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            flow_stop_q <= flow_stop_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// tb/tb_uart_byte_fifo.sv - directed self-checking bench for uart_byte_fifo
module tb_uart_byte_fifo;

    logic       clk;
    logic       reset_;
    logic       in_req;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_req;
    logic       out_ready;
    logic [7:0] out_data;
    logic       flow_stop;
    logic       overflow;
    logic       clr_ovf;
    logic [4:0] level;

    int errors;
    int checks;
    logic [7:0] model_q[$];
    logic [7:0] seq;

    uart_byte_fifo dut (
        .clk       (clk),
        .reset_    (reset_),
        .in_req    (in_req),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_req   (out_req),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flow_stop (flow_stop),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: sim time budget expired before summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_req  = 1'b1;
        in_data = b;
        tick();
        in_req  = 1'b0;
        model_q.push_back(b);
    endtask

    task automatic pop_byte(input string tag);
        logic [7:0] exp_b;
        exp_b = model_q.pop_front();
        check({tag, "_req"}, {31'd0, out_req}, 32'd1);
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, exp_b});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        seq = 8'h60;
        reset_ = 1'b0;
        in_req = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        clr_ovf = 1'b0;
        tick();
        tick();
        reset_ = 1'b1;
        tick();

        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_out_req", {31'd0, out_req}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_flow_stop", {31'd0, flow_stop}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);

        // 1: three pushes, no drain
        push_byte(8'h41);
        check("t1_latency_req", {31'd0, out_req}, 32'd1);
        check("t1_latency_data", {24'd0, out_data}, 32'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        check("t1_level", {27'd0, level}, 32'd3);
        check("t1_head", {24'd0, out_data}, 32'h41);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);

        // 2: drain in order
        for (int i = 0; i < 3; i++) pop_byte("t2_pop");
        check("t2_out_req", {31'd0, out_req}, 32'd0);
        check("t2_level", {27'd0, level}, 32'd0);

        // 3: fill to full, overflow, set-wins-over-clear, drain
        for (int i = 0; i < 16; i++) begin
            check("t3_in_ready_fill", {31'd0, in_ready}, 32'd1);
            push_byte(8'h10 + 8'(i));
        end
        check("t3_full_level", {27'd0, level}, 32'd16);
        check("t3_full_in_ready", {31'd0, in_ready}, 32'd0);
        check("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
        in_req = 1'b1;
        in_data = 8'hFF;
        tick();
        check("t3_ovf_set", {31'd0, overflow}, 32'd1);
        check("t3_ovf_level", {27'd0, level}, 32'd16);
        clr_ovf = 1'b1;
        tick();
        check("t3_set_wins", {31'd0, overflow}, 32'd1);
        in_req = 1'b0;
        tick();
        clr_ovf = 1'b0;
        check("t3_ovf_cleared_by_clr", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 16; i++) pop_byte("t3_drain");
        check("t3_empty", {27'd0, level}, 32'd0);
        check("t3_overflow_stays_clear", {31'd0, overflow}, 32'd0);

        // 4: flow_stop hysteresis
        for (int i = 0; i < 11; i++) push_byte(8'h80 + 8'(i));
        check("t4_fs_at11", {31'd0, flow_stop}, 32'd0);
        push_byte(8'h8B);
        check("t4_level12", {27'd0, level}, 32'd12);
        check("t4_fs_at12", {31'd0, flow_stop}, 32'd1);
        for (int i = 0; i < 3; i++) pop_byte("t4_pop");
        check("t4_level9", {27'd0, level}, 32'd9);
        check("t4_fs_at9", {31'd0, flow_stop}, 32'd1);
        pop_byte("t4_pop");
        check("t4_level8", {27'd0, level}, 32'd8);
        check("t4_fs_at8", {31'd0, flow_stop}, 32'd0);
        for (int i = 0; i < 8; i++) pop_byte("t4_drain");
        check("t4_empty", {27'd0, level}, 32'd0);

        // 5: steady push+pop at level 5 across pointer wrap
        for (int i = 0; i < 5; i++) begin
            push_byte(seq);
            seq++;
        end
        for (int i = 0; i < 40; i++) begin
            in_req = 1'b1;
            in_data = seq;
            out_ready = 1'b1;
            check("t5_data", {24'd0, out_data}, {24'd0, model_q[0]});
            tick();
            void'(model_q.pop_front());
            model_q.push_back(seq);
            seq++;
            check("t5_level", {27'd0, level}, 32'd5);
        end
        in_req = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) pop_byte("t5_drain");

        // 6: asynchronous reset mid-stream at level 7
        for (int i = 0; i < 7; i++) push_byte(8'hA0 + 8'(i));
        check("t6_level7", {27'd0, level}, 32'd7);
        #2;
        reset_ = 1'b0;
        #1;
        check("t6_async_level", {27'd0, level}, 32'd0);
        check("t6_async_out_req", {31'd0, out_req}, 32'd0);
        check("t6_async_in_ready", {31'd0, in_ready}, 32'd1);
        check("t6_async_fs", {31'd0, flow_stop}, 32'd0);
        model_q.delete();
        tick();
        reset_ = 1'b1;
        tick();
        check("t6_post_out_req", {31'd0, out_req}, 32'd0);
        push_byte(8'h55);
        check("t6_post_level", {27'd0, level}, 32'd1);
        pop_byte("t6_first");
        check("t6_final_empty", {27'd0, level}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
